clint_axi: RTL and testbench

Core-local interruptor that sits downstream of the pipeline's dmem AXI4-Lite master port and upstream of its `irq_timer` and `irq_software` inputs. It holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a 1-bit `msip` register, all reachable over an AXI4-Lite slave. It raises `irq_timer` while `mtime >= mtimecmp` and drives `irq_software` from `msip`.

---
 rtl/clint_pkg.sv | 69 ++++++
 rtl/clint_mtime.sv | 79 +++++++
 rtl/clint_axi.sv | 174 +++++++++++++++++
 tb/tb_clint_axi.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, AXI response codes, FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package clint_pkg;

    // Byte offsets of the mapped registers (address bits [1:0] are dropped before compare)
    localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_0008;
    localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_000C;
    localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_0010;
    localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_0014;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Decoded register target of a bus access
    typedef enum logic [2:0] {
        SEL_MSIP,
        SEL_MTIMECMP_LO,
        SEL_MTIMECMP_HI,
        SEL_MTIME_LO,
        SEL_MTIME_HI,
        SEL_NONE
    } reg_sel_e;

    // One accepted bus write, handed from the AXI front end to the timer block
    typedef struct packed {
        logic        en;
        reg_sel_e    sel;
        logic [31:0] dat;
        logic [3:0]  strb;
    } clint_wr_t;

    // Map an already-masked byte offset onto a register select
    function automatic reg_sel_e clint_decode(input logic [31:0] off);
        reg_sel_e sel;
        case (off)
            CLINT_MSIP:        sel = SEL_MSIP;
            CLINT_MTIMECMP_LO: sel = SEL_MTIMECMP_LO;
            CLINT_MTIMECMP_HI: sel = SEL_MTIMECMP_HI;
            CLINT_MTIME_LO:    sel = SEL_MTIME_LO;
            CLINT_MTIME_HI:    sel = SEL_MTIME_HI;
            default:           sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Per-byte merge: strobed bytes take new data, the rest keep the old value
    function automatic logic [31:0] strb_merge(input logic [31:0] old_dat,
                                               input logic [31:0] new_dat,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_dat[i*8 +: 8] : old_dat[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// 64-bit mtime counter, mtimecmp register and timer interrupt; optional tick prescaler under CLINT_PRESCALER_EN.
// Latency: writes land at the end of the accept cycle; irq_timer follows the registers one cycle later.
// Backpressure: none, every write presented with wr.en is taken in that cycle.
module clint_mtime
    import clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  clint_wr_t   wr,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        irq_timer
);

    // A prescale of zero would never produce a tick
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("clint_mtime: PRESCALE must be at least 1");
    end

    logic tick;

`ifdef CLINT_PRESCALER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_LAST);

    // Free-running divider; bus writes never touch it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    logic [63:0] mtime_inc;
    logic [63:0] mtime_nxt;
    logic [63:0] cmp_nxt;

    // Increment first, then overlay any written bytes so unwritten bytes keep the tick
    always_comb begin
        mtime_inc = tick ? (mtime + 64'd1) : mtime;
        mtime_nxt = mtime_inc;
        cmp_nxt   = mtimecmp;
        if (wr.en) begin
            case (wr.sel)
                SEL_MTIME_LO:    mtime_nxt[31:0]  = strb_merge(mtime_inc[31:0],  wr.dat, wr.strb);
                SEL_MTIME_HI:    mtime_nxt[63:32] = strb_merge(mtime_inc[63:32], wr.dat, wr.strb);
                SEL_MTIMECMP_LO: cmp_nxt[31:0]    = strb_merge(mtimecmp[31:0],   wr.dat, wr.strb);
                SEL_MTIMECMP_HI: cmp_nxt[63:32]   = strb_merge(mtimecmp[63:32],  wr.dat, wr.strb);
                default:         ;
            endcase
        end
    end

    // Counter/compare state; irq compares the values held this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            irq_timer <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= cmp_nxt;
            irq_timer <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/clint_axi.sv
// AXI4-Lite CLINT: msip, mtimecmp and mtime registers driving irq_software/irq_timer (prescaler via CLINT_PRESCALER_EN).
// Latency: write response and read data one cycle after the accept cycle; irqs two cycles after the update.
// Backpressure: a write needs awvalid and wvalid together; one outstanding write and one read, held until bready/rready.
module clint_axi
    import clint_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int PRESCALE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic        irq_timer,
    output logic        irq_software
);

    // Keep the decoded address bits only, word aligned
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_WIDTH) - 64'd1) & ~32'd3;

    // Protection attributes carry no meaning for this block
    logic unused_prot;
    assign unused_prot = ^{axi_awprot, axi_arprot};

    wr_state_e   w_state, w_state_nxt;
    rd_state_e   r_state, r_state_nxt;
    logic        w_hs, r_hs;
    reg_sel_e    aw_sel, ar_sel;
    logic        msip;
    logic [63:0] mtime, mtimecmp;
    logic [31:0] rd_mux;
    clint_wr_t   wr;

    assign aw_sel = clint_decode(axi_awaddr & ADDR_MASK);
    assign ar_sel = clint_decode(axi_araddr & ADDR_MASK);

    assign wr.en   = w_hs;
    assign wr.sel  = aw_sel;
    assign wr.dat  = axi_wdata;
    assign wr.strb = axi_wstrb;

    clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .mtime     (mtime),
        .mtimecmp  (mtimecmp),
        .irq_timer (irq_timer)
    );

    // Write FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = w_state;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        w_hs        = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (axi_awvalid && axi_wvalid) begin
                    axi_awready = 1'b1;
                    axi_wready  = 1'b1;
                    w_hs        = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state, response code and the msip bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state   <= W_IDLE;
            axi_bresp <= AXI_RESP_OKAY;
            msip      <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (w_hs) begin
                axi_bresp <= (aw_sel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                if (aw_sel == SEL_MSIP && axi_wstrb[0]) begin
                    msip <= axi_wdata[0];
                end
            end
        end
    end

    // Software interrupt is a registered copy of msip
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_software <= 1'b0;
        end else begin
            irq_software <= msip;
        end
    end

    // Read data selection from the current register values
    always_comb begin
        rd_mux = '0;
        case (ar_sel)
            SEL_MSIP:        rd_mux = {31'd0, msip};
            SEL_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            SEL_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            SEL_MTIME_LO:    rd_mux = mtime[31:0];
            SEL_MTIME_HI:    rd_mux = mtime[63:32];
            default:         rd_mux = '0;
        endcase
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        r_state_nxt = r_state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        r_hs        = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (axi_arvalid) begin
                    axi_arready = 1'b1;
                    r_hs        = 1'b1;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                if (axi_rready) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state plus captured data/response, held until rready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= R_IDLE;
            axi_rdata <= '0;
            axi_rresp <= AXI_RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (r_hs) begin
                axi_rdata <= rd_mux;
                axi_rresp <= (ar_sel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_clint_axi.sv
// Self-checking bench for clint_axi against a cycle-indexed reference model of the timer registers.
// Latency: n/a (testbench).
// Backpressure: exercised through bready hold-off and continuous valid streams.
module tb_clint_axi;

`ifdef CLINT_PRESCALER_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        irq_timer;
    logic        irq_software;

    int vectors     = 0;
    int miscompares = 0;
    longint cyc     = 0;

    // Reference model state: mtime = m_base + ticks since m_base_cyc
    logic [63:0] m_base;
    longint      m_base_cyc;
    longint      rst_cyc;
    logic [63:0] m_cmp;
    logic        m_msip;

    clint_axi #(.ADDR_WIDTH(5), .PRESCALE(P)) dut (
        .clk(clk), .reset(reset),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .irq_timer(irq_timer), .irq_software(irq_software)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ticks completed before cycle c since reset release
    function automatic longint ticks(input longint c);
        return (c - rst_cyc) / longint'(P);
    endfunction

    function automatic logic [63:0] mt_at(input longint c);
        return m_base + 64'(ticks(c) - ticks(m_base_cyc));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        logic [4:0] off;
        off = a[4:0] & 5'h1C;
        return (off == 5'h00 || off == 5'h08 || off == 5'h0C || off == 5'h10 || off == 5'h14) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input longint c);
        logic [4:0]  off;
        logic [63:0] m;
        off = a[4:0] & 5'h1C;
        m   = mt_at(c);
        case (off)
            5'h00:   return {31'd0, m_msip};
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return m[31:0];
            5'h14:   return m[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input longint w);
        logic [4:0]  off;
        logic [63:0] cur;
        off = a[4:0] & 5'h1C;
        case (off)
            5'h00: if (s[0]) m_msip = d[0];
            5'h08: m_cmp[31:0]  = merge(m_cmp[31:0], d, s);
            5'h0C: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
            5'h10, 5'h14: begin
                cur = mt_at(w) + 64'(ticks(w + 1) - ticks(w));
                if (off == 5'h10) cur[31:0]  = merge(cur[31:0], d, s);
                else              cur[63:32] = merge(cur[63:32], d, s);
                m_base     = cur;
                m_base_cyc = w + 1;
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset(input longint c);
        rst_cyc    = c;
        m_base     = '0;
        m_base_cyc = c;
        m_cmp      = '1;
        m_msip     = 1'b0;
    endfunction

    // Issue one write; returns accept cycle and the response seen one cycle later
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output longint hs, output logic [1:0] resp, output logic got_b);
        @(posedge clk); #1;
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi_awready === 1'b1 && axi_wready === 1'b1) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            vectors++; miscompares++;
            $display("FAIL write_accept: addr %h got no awready/wready within 20 cycles, required accept", a);
        end else begin
            model_write(a, d, s, hs);
        end
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        @(negedge clk);
        got_b = axi_bvalid;
        resp  = axi_bresp;
    endtask

    // Issue one read; returns accept cycle and data/response seen one cycle later
    task automatic axi_read(input logic [31:0] a, output longint hs, output logic [31:0] rd,
                            output logic [1:0] resp, output logic got_r);
        @(posedge clk); #1;
        axi_araddr = a; axi_arvalid = 1'b1;
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi_arready === 1'b1) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            vectors++; miscompares++;
            $display("FAIL read_accept: addr %h got no arready within 20 cycles, required accept", a);
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        @(negedge clk);
        got_r = axi_rvalid;
        rd    = axi_rdata;
        resp  = axi_rresp;
    endtask

    // Read an address and compare against the model
    task automatic read_check(input logic [31:0] a, input string name);
        longint hs; logic [31:0] rd; logic [1:0] rr; logic got;
        logic [31:0] exp;
        axi_read(a, hs, rd, rr, got);
        exp = model_read(a, hs);
        vectors++;
        if (got !== 1'b1 || rd !== exp || rr !== model_resp(a)) begin
            miscompares++;
            $display("FAIL %s: rvalid=%b rdata=%h rresp=%b, required rvalid=1 rdata=%h rresp=%b",
                     name, got, rd, rr, exp, model_resp(a));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: got %b required 00000",
                     {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid});
        end
        vectors++;
        if ({axi_bresp, axi_rresp} !== 4'b0 || axi_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h required 0", axi_bresp, axi_rresp, axi_rdata);
        end
        vectors++;
        if ({irq_timer, irq_software} !== 2'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b required 00", {irq_timer, irq_software});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset(cyc);
        read_check(32'h14, "reset_mtime_hi");
        read_check(32'h08, "reset_mtimecmp_lo");
        vectors++;
        if (irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq_timer: got %b required 0", irq_timer);
        end
    endtask

    task automatic test_timer_irq();
        longint hs, w, c, exp, first;
        logic [1:0] rr; logic got;
        axi_write(32'h08, 32'h20, 4'hF, hs, rr, got);
        axi_write(32'h10, 32'h0, 4'hF, w, rr, got);
        axi_write(32'h0C, 32'h0, 4'hF, c, rr, got);
        vectors++;
        if (irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL timer_irq_early: got %b required 0", irq_timer);
        end
        exp = -1;
        for (longint k = c + 2; k < c + 400; k++) begin
            if (mt_at(k - 1) >= m_cmp) begin
                exp = k;
                break;
            end
        end
        first = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (irq_timer === 1'b1) begin
                first = cyc;
                break;
            end
        end
        vectors++;
        if (first != exp) begin
            miscompares++;
            $display("FAIL timer_irq_rise: rose in cycle %0d, required cycle %0d (mtime write cycle %0d)", first, exp, w);
        end
    endtask

    task automatic test_software_irq();
        longint hs; logic [1:0] rr; logic got;
        axi_write(32'h00, 32'h1, 4'h1, hs, rr, got);
        vectors++;
        if (got !== 1'b1 || rr !== 2'b00) begin
            miscompares++;
            $display("FAIL msip_set_resp: bvalid=%b bresp=%b required 1/00", got, rr);
        end
        vectors++;
        if (irq_software !== 1'b0) begin
            miscompares++;
            $display("FAIL msip_set_n1: got %b required 0", irq_software);
        end
        @(negedge clk);
        vectors++;
        if (irq_software !== 1'b1) begin
            miscompares++;
            $display("FAIL msip_set_n2: got %b required 1", irq_software);
        end
        axi_write(32'h00, 32'h0, 4'hF, hs, rr, got);
        vectors++;
        if (irq_software !== 1'b1) begin
            miscompares++;
            $display("FAIL msip_clr_n1: got %b required 1", irq_software);
        end
        @(negedge clk);
        vectors++;
        if (irq_software !== 1'b0) begin
            miscompares++;
            $display("FAIL msip_clr_n2: got %b required 0", irq_software);
        end
    endtask

    task automatic test_wrap_and_strobe();
        longint hs; logic [1:0] rr; logic got;
        longint rh; logic [31:0] rd; logic got_r;
        axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, hs, rr, got);
        axi_write(32'h10, 32'hFFFF_FFFF, 4'hF, hs, rr, got);
        read_check(32'h14, "wrap_mtime_hi");
        read_check(32'h10, "wrap_mtime_lo");
        axi_write(32'h14, 32'h0000_AB00, 4'b0010, hs, rr, got);
        axi_read(32'h14, rh, rd, rr, got_r);
        vectors++;
        if (got_r !== 1'b1 || rd !== model_read(32'h14, rh) || rd[15:8] !== 8'hAB) begin
            miscompares++;
            $display("FAIL strobe_mtime_hi: rdata=%h required %h with byte1 ab", rd, model_read(32'h14, rh));
        end
    endtask

    task automatic test_unmapped();
        longint hs; logic [1:0] rr; logic got;
        read_check(32'h18, "unmapped_read");
        axi_bready = 1'b0;
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, hs, rr, got);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b10) begin
                miscompares++;
                $display("FAIL unmapped_bhold: cycle %0d bvalid=%b bresp=%b required 1/10", i, axi_bvalid, axi_bresp);
            end
            @(negedge clk);
        end
        axi_bready = 1'b1;
        @(negedge clk);
        vectors++;
        if (axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL unmapped_bdrop: bvalid=%b required 0", axi_bvalid);
        end
        read_check(32'h00, "unmapped_msip_kept");
        read_check(32'h08, "unmapped_cmp_lo_kept");
        read_check(32'h0C, "unmapped_cmp_hi_kept");
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        @(posedge clk); #1;
        axi_araddr = 32'h00; axi_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi_arready === 1'b1) n++;
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        vectors++;
        if (n != 10) begin
            miscompares++;
            $display("FAIL b2b_reads: %0d accepts in 20 cycles, required 10", n);
        end
        repeat (2) @(posedge clk);
        n = 0;
        #1;
        axi_awaddr = 32'h00; axi_wdata = 32'h0; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi_awready === 1'b1 && axi_wready === 1'b1) n++;
        end
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        m_msip = 1'b0;
        vectors++;
        if (n != 10) begin
            miscompares++;
            $display("FAIL b2b_writes: %0d accepts in 20 cycles, required 10", n);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_concurrent();
        longint hw, hr; logic [1:0] bw, rr; logic gb, gr; logic [31:0] rd;
        fork
            axi_write(32'h00, 32'h1, 4'h1, hw, bw, gb);
            axi_read(32'h10, hr, rd, rr, gr);
        join
        vectors++;
        if (hw != hr || gb !== 1'b1 || gr !== 1'b1) begin
            miscompares++;
            $display("FAIL concurrent_accept: write cycle %0d read cycle %0d bvalid=%b rvalid=%b, required same cycle and both valid",
                     hw, hr, gb, gr);
        end
        vectors++;
        if (rd !== model_read(32'h10, hr) || rr !== 2'b00) begin
            miscompares++;
            $display("FAIL concurrent_read: rdata=%h rresp=%b required %h/00", rd, rr, model_read(32'h10, hr));
        end
        read_check(32'h00, "concurrent_msip");
    endtask

    task automatic test_random();
        longint hs; logic [1:0] rr; logic got;
        logic [31:0] r, a, d; logic [2:0] k; logic [3:0] s;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            k = 3'($urandom_range(0, 7));
            a = {r[31:5], k, r[1:0]};
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom();
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, hs, rr, got);
                vectors++;
                if (got !== 1'b1 || rr !== model_resp(a)) begin
                    miscompares++;
                    $display("FAIL random_write: addr %h bvalid=%b bresp=%b required 1/%b", a, got, rr, model_resp(a));
                end
            end else begin
                read_check(a, "random_read");
            end
        end
    endtask

    task automatic test_reset_midflight();
        longint hs; logic [1:0] rr; logic got;
        axi_bready = 1'b0;
        axi_write(32'h00, 32'h1, 4'h1, hs, rr, got);
        @(negedge clk);
        vectors++;
        if (axi_bvalid !== 1'b1 || irq_software !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pending: bvalid=%b irq_software=%b required 1/1", axi_bvalid, irq_software);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (axi_bvalid !== 1'b0 || irq_software !== 1'b0 || irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_drop: bvalid=%b irq_software=%b irq_timer=%b required 000",
                     axi_bvalid, irq_software, irq_timer);
        end
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset(cyc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (axi_bvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_no_resp: cycle %0d bvalid=%b required 0", i, axi_bvalid);
            end
        end
        axi_bready = 1'b1;
        read_check(32'h00, "midreset_msip");
        read_check(32'h08, "midreset_cmp_lo");
        read_check(32'h0C, "midreset_cmp_hi");
        read_check(32'h14, "midreset_mtime_hi");
        read_check(32'h10, "midreset_mtime_lo");
        repeat (5) @(posedge clk);
        read_check(32'h10, "midreset_mtime_lo_later");
    endtask

    initial begin
        reset = 1'b0;
        axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
        axi_bready = 1'b1;
        axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0;
        axi_rready = 1'b1;
        model_reset(0);
        test_reset();
        test_timer_irq();
        test_software_irq();
        test_wrap_and_strobe();
        test_unmapped();
        test_back_to_back();
        test_concurrent();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
